// File: rtl/ulx3s_pll_phase_ctrl_if.sv
// Request/response handshake between the SDRAM calibration logic and the
// EHXPLLL dynamic phase-shift controller.
interface ulx3s_pll_phase_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_target;
  logic       req_dir;
  logic [7:0] req_count;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output req_valid, req_target, req_dir, req_count,
    input  req_ready, busy, done, err
  );

  modport slave (
    input  req_valid, req_target, req_dir, req_count,
    output req_ready, busy, done, err
  );
endinterface

// File: rtl/ulx3s_pll_phase_ctrl.sv
// Steps CLKOS/CLKOS2 of the ECP5 EHXPLLL via PHASESEL/DIR/STEP and tracks the
// resulting phase position of each output; runs in the PLL clkIO domain.
module ulx3s_pll_phase_ctrl #(
  parameter int unsigned SETUP_CYCLES    = 2,
  parameter int unsigned PULSE_CYCLES    = 4,
  parameter int unsigned GAP_CYCLES      = 8,
  parameter int unsigned STEPS_PER_CYCLE = 48,
  parameter int unsigned LOCK_CYCLES     = 16,
  localparam int unsigned PW             = $clog2(STEPS_PER_CYCLE)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   locked_i,
  ulx3s_pll_phase_ctrl_if.slave  req_if,
  output logic                   pll_ready_o,
  output logic [PW-1:0]          pos_clkos_o,
  output logic [PW-1:0]          pos_clkos2_o,
  output logic [1:0]             pll_phasesel_o,
  output logic                   pll_phasedir_o,
  output logic                   pll_phasestep_o,
  output logic                   pll_phaseloadreg_o
);

  localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {
    S_WAITLOCK,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_e;

  logic          lock_s1_q, lock_s2_q;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          pll_ready_q;

  state_e        state_q;
  logic [7:0]    tmr_q;
  logic [7:0]    remaining_q;
  logic          target_q, dir_q;
  logic [PW-1:0] pos0_q, pos1_q;
  logic          step_q;
  logic          ready_q, busy_q, done_q, err_q;

  function automatic logic [PW-1:0] step_pos(input logic [PW-1:0] p, input logic dir);
    if (dir) return (p == PW'(STEPS_PER_CYCLE - 1)) ? '0 : p + PW'(1);
    else     return (p == '0) ? PW'(STEPS_PER_CYCLE - 1) : p - PW'(1);
  endfunction

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (!lock_s2_q)                            lock_cnt_d = '0;
    else if (lock_cnt_q != LW'(LOCK_CYCLES))   lock_cnt_d = lock_cnt_q + LW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_s1_q   <= 1'b0;
      lock_s2_q   <= 1'b0;
      lock_cnt_q  <= '0;
      pll_ready_q <= 1'b0;
    end else begin
      lock_s1_q   <= locked_i;
      lock_s2_q   <= lock_s1_q;
      lock_cnt_q  <= lock_cnt_d;
      pll_ready_q <= (lock_cnt_d == LW'(LOCK_CYCLES));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_WAITLOCK;
      tmr_q       <= '0;
      remaining_q <= '0;
      target_q    <= 1'b0;
      dir_q       <= 1'b0;
      pos0_q      <= '0;
      pos1_q      <= '0;
      step_q      <= 1'b1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (!lock_s2_q) begin
        state_q <= S_WAITLOCK;
        tmr_q   <= '0;
        pos0_q  <= '0;
        pos1_q  <= '0;
        step_q  <= 1'b1;
        ready_q <= 1'b0;
        busy_q  <= 1'b0;
        err_q   <= (state_q != S_IDLE) && (state_q != S_WAITLOCK);
      end else begin
        case (state_q)
          S_WAITLOCK: begin
            if (pll_ready_q) begin
              state_q <= S_IDLE;
              ready_q <= 1'b1;
            end
          end
          S_IDLE: begin
            if (req_if.req_valid && ready_q) begin
              target_q    <= req_if.req_target;
              dir_q       <= req_if.req_dir;
              remaining_q <= req_if.req_count;
              ready_q     <= 1'b0;
              busy_q      <= 1'b1;
              tmr_q       <= '0;
              state_q     <= (req_if.req_count == '0) ? S_DONE : S_SETUP;
            end else begin
              ready_q <= 1'b1;
            end
          end
          S_SETUP: begin
            if (tmr_q == 8'(SETUP_CYCLES - 1)) begin
              tmr_q   <= '0;
              step_q  <= 1'b0;
              state_q <= S_PULSE;
            end else begin
              tmr_q <= tmr_q + 8'd1;
            end
          end
          S_PULSE: begin
            if (tmr_q == 8'(PULSE_CYCLES - 1)) begin
              tmr_q       <= '0;
              step_q      <= 1'b1;
              state_q     <= S_GAP;
              remaining_q <= remaining_q - 8'd1;
              if (target_q) pos1_q <= step_pos(pos1_q, dir_q);
              else          pos0_q <= step_pos(pos0_q, dir_q);
            end else begin
              tmr_q <= tmr_q + 8'd1;
            end
          end
          S_GAP: begin
            if (tmr_q == 8'(GAP_CYCLES - 1)) begin
              tmr_q   <= '0;
              state_q <= (remaining_q != '0) ? S_SETUP : S_DONE;
            end else begin
              tmr_q <= tmr_q + 8'd1;
            end
          end
          S_DONE: begin
            // ready_q stays low here so it rises one edge after the done pulse.
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_WAITLOCK;
        endcase
      end
    end
  end

  assign req_if.req_ready  = ready_q;
  assign req_if.busy       = busy_q;
  assign req_if.done       = done_q;
  assign req_if.err        = err_q;

  assign pll_ready_o        = pll_ready_q;
  assign pos_clkos_o        = pos0_q;
  assign pos_clkos2_o       = pos1_q;
  assign pll_phasesel_o     = {1'b0, target_q};
  assign pll_phasedir_o     = dir_q;
  assign pll_phasestep_o    = step_q;
  assign pll_phaseloadreg_o = 1'b1;

endmodule

// File: tb/tb_ulx3s_pll_phase_ctrl.sv
// Scoreboard bench for ulx3s_pll_phase_ctrl: requests push expected results,
// an independent monitor checks pulses, positions, done/err timing.
module tb_ulx3s_pll_phase_ctrl;
  localparam int STEPS  = 48;
  localparam int PERIOD = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b1;
  logic       pll_ready;
  logic [5:0] pos0, pos1;
  logic [1:0] sel;
  logic       pdir, pstep, pload;

  ulx3s_pll_phase_ctrl_if bus ();

  ulx3s_pll_phase_ctrl #(
    .SETUP_CYCLES   (2),
    .PULSE_CYCLES   (4),
    .GAP_CYCLES     (8),
    .STEPS_PER_CYCLE(48),
    .LOCK_CYCLES    (16)
  ) u_dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .locked_i          (locked),
    .req_if            (bus.slave),
    .pll_ready_o       (pll_ready),
    .pos_clkos_o       (pos0),
    .pos_clkos2_o      (pos1),
    .pll_phasesel_o    (sel),
    .pll_phasedir_o    (pdir),
    .pll_phasestep_o   (pstep),
    .pll_phaseloadreg_o(pload)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int accepts = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!rst && bus.req_valid && bus.req_ready) accepts <= accepts + 1;

  typedef struct {
    int acc;
    int n;
    int tgt;
    int dir;
    int start;
    int exp0;
    int exp1;
    bit aborted;
    int err_edge;
  } req_t;

  req_t sb[$];
  int   mpos[2];
  int   issued = 0;
  int   total = 0;
  int   bad = 0;

  function automatic int wrapm(input int v);
    return ((v % STEPS) + STEPS) % STEPS;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT behaviour against the queued expectations.
  initial begin : monitor
    bit   prev_step;
    int   fall_idx;
    int   low_len;
    req_t e;
    prev_step = 1'b1;
    fall_idx  = 0;
    low_len   = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_step && !pstep) begin
          if (sb.size() > 0) chk("fall_edge", cyc - sb[0].acc, 2 + PERIOD * fall_idx);
          else               chk("pulse_without_request", 1, 0);
          fall_idx++;
          low_len = 0;
        end
        if (!pstep) low_len++;
        if (!prev_step && pstep && !bus.err) begin
          chk("low_len", low_len, 4);
          if (sb.size() > 0) begin
            e = sb[0];
            chk("step_pos", e.tgt ? int'(pos1) : int'(pos0),
                wrapm(e.start + (e.dir ? fall_idx : -fall_idx)));
          end
        end
        if (bus.done) begin
          if (sb.size() == 0) chk("done_unexpected", 1, 0);
          else begin
            e = sb.pop_front();
            chk("done_not_aborted", int'(e.aborted), 0);
            chk("done_latency", cyc - e.acc, (e.n == 0) ? 1 : e.n * PERIOD + 1);
            chk("pulse_count", fall_idx, e.n);
            chk("pos_clkos", int'(pos0), e.exp0);
            chk("pos_clkos2", int'(pos1), e.exp1);
            chk("phasesel", int'(sel), e.tgt);
            chk("phasedir", int'(pdir), e.dir);
            chk("busy_at_done", int'(bus.busy), 0);
          end
          fall_idx = 0;
        end
        if (bus.err) begin
          if (sb.size() == 0) chk("err_unexpected", 1, 0);
          else begin
            e = sb.pop_front();
            chk("err_expected", int'(e.aborted), 1);
            chk("err_edge", cyc, e.err_edge);
            chk("err_pos_clkos", int'(pos0), 0);
            chk("err_pos_clkos2", int'(pos1), 0);
            chk("err_phasestep", int'(pstep), 1);
          end
          fall_idx = 0;
        end
        prev_step = pstep;
      end
    end
  end

  task automatic issue(input int t, input int d, input int n, input bit hold);
    int   waited;
    req_t e;
    bus.req_target = t[0];
    bus.req_dir    = d[0];
    bus.req_count  = n[7:0];
    bus.req_valid  = 1'b1;
    waited = 0;
    while (!bus.req_ready) begin
      @(negedge clk);
      waited++;
      if (waited > 3000) begin
        chk("req_ready_timeout", 0, 1);
        bus.req_valid = 1'b0;
        return;
      end
    end
    e.acc      = cyc + 1;
    e.n        = n;
    e.tgt      = t;
    e.dir      = d;
    e.start    = mpos[t];
    e.aborted  = 1'b0;
    e.err_edge = 0;
    mpos[t]    = wrapm(mpos[t] + (d ? n : -n));
    e.exp0     = mpos[0];
    e.exp1     = mpos[1];
    sb.push_back(e);
    issued++;
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
    chk("busy_after_accept", int'(bus.busy), 1);
    chk("ready_low_after_accept", int'(bus.req_ready), 0);
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while (sb.size() != 0 || !bus.req_ready) begin
      @(negedge clk);
      waited++;
      if (waited > 3000) begin
        chk("idle_timeout", 0, 1);
        return;
      end
    end
  endtask

  initial begin : driver
    int c;
    int waited;
    bus.req_valid  = 1'b0;
    bus.req_target = 1'b0;
    bus.req_dir    = 1'b0;
    bus.req_count  = '0;
    mpos[0] = 0;
    mpos[1] = 0;
    repeat (3) @(negedge clk);

    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_pll_ready", int'(pll_ready), 0);
    chk("rst_pos_clkos", int'(pos0), 0);
    chk("rst_pos_clkos2", int'(pos1), 0);
    chk("rst_phasesel", int'(sel), 0);
    chk("rst_phasedir", int'(pdir), 0);
    chk("rst_phasestep", int'(pstep), 1);
    chk("rst_phaseloadreg", int'(pload), 1);

    rst = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      chk("lock_pll_ready", int'(pll_ready), int'(k >= 18));
      chk("lock_req_ready", int'(bus.req_ready), int'(k >= 19));
    end

    issue(0, 1, 1, 1'b0);  wait_idle();
    issue(1, 0, 3, 1'b0);  wait_idle();
    issue(0, 1, 48, 1'b0); wait_idle();
    issue(1, 1, 0, 1'b0);  wait_idle();

    // Back-pressure: valid stays high across the whole request.
    issue(0, 0, 2, 1'b1);
    waited = 0;
    while (!bus.done && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("hold_done_seen", int'(bus.done), 1);
    bus.req_valid = 1'b0;
    wait_idle();
    chk("hold_single_accept", accepts, issued);

    // Lock loss during the first pulse of a 5-step request.
    issue(1, 1, 5, 1'b0);
    waited = 0;
    while (pstep && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("lockloss_pulse_seen", int'(pstep), 0);
    c = cyc;
    sb[0].aborted  = 1'b1;
    sb[0].err_edge = c + 3;
    locked = 1'b0;
    repeat (2) @(negedge clk);
    chk("lockloss_step_still_low", int'(pstep), 0);
    @(negedge clk);
    chk("lockloss_step_high", int'(pstep), 1);
    mpos[0] = 0;
    mpos[1] = 0;
    repeat (5) @(negedge clk);
    chk("lockloss_pll_ready", int'(pll_ready), 0);
    chk("lockloss_req_ready", int'(bus.req_ready), 0);
    chk("lockloss_busy", int'(bus.busy), 0);
    chk("lockloss_sb_empty", sb.size(), 0);
    locked = 1'b1;
    c = cyc;
    waited = 0;
    while (!bus.req_ready && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    chk("requalify_edges", cyc - c, 19);

    repeat (14) begin
      int t, d, n;
      t = int'($urandom_range(0, 1));
      d = int'($urandom_range(0, 1));
      n = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6));
      issue(t, d, n, 1'b0);
    end
    wait_idle();
    chk("accept_count", accepts, issued);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
